// File: rtl/hdmi_wave_writer.sv
// Multi-channel column sweep writer for the ping-pong HDMI framebuffer.
// Define HDMI_WAVE_LINE_EN to join consecutive samples with vertical lines instead of dots.
module hdmi_wave_writer #(
    parameter int NUM_CH      = 2,
    parameter int VAL_RES     = 16,
    parameter int WIDTH       = 1024,
    parameter int HEIGHT      = 480,
    parameter int LOG2_WIDTH  = 10,
    parameter int LOG2_HEIGHT = 9,
    parameter int ADDR_WIDTH  = 19
) (
    input  logic                      clkWR,
    input  logic                      rst,
    input  logic [NUM_CH*VAL_RES-1:0] valIn,
    input  logic                      valValid,
    output logic                      valReady,
    output logic                      swapReq,
    input  logic                      swapAck,
    output logic                      bufSel,
    output logic                      frameDone,
    output logic                      EN0,
    output logic                      WE0,
    output logic                      EN1,
    output logic                      WE1,
    output logic [ADDR_WIDTH-1:0]     addrB0,
    output logic [ADDR_WIDTH-1:0]     addrB1,
    output logic [NUM_CH-1:0]         WD
);

    localparam int PW = VAL_RES + LOG2_HEIGHT;
    localparam logic [PW-1:0]          H_P   = PW'(HEIGHT);
    localparam logic [LOG2_HEIGHT-1:0] H_MAX = LOG2_HEIGHT'(HEIGHT - 1);
    localparam logic [LOG2_WIDTH-1:0]  W_MAX = LOG2_WIDTH'(WIDTH - 1);

    typedef enum logic [1:0] {LOAD, MAP, SWEEP, SWAP} state_t;

    state_t state, state_d;
    logic [NUM_CH*VAL_RES-1:0] val_q;
    logic [LOG2_HEIGHT-1:0]    row_q    [NUM_CH];
    logic [LOG2_HEIGHT-1:0]    row_calc [NUM_CH];
    logic [LOG2_HEIGHT-1:0]    row_src  [NUM_CH];
    logic [LOG2_HEIGHT-1:0]    row_cnt, row_cnt_d, wr_row;
    logic [LOG2_WIDTH-1:0]     x, x_d;
    logic                      buf_d, wr_d, frame_d;
    logic [NUM_CH-1:0]         wd_d;
    logic                      accept;

`ifdef HDMI_WAVE_LINE_EN
    logic [LOG2_HEIGHT-1:0]    prev_q   [NUM_CH];
    logic [LOG2_HEIGHT-1:0]    prev_src [NUM_CH];
    logic [LOG2_HEIGHT-1:0]    lo_v     [NUM_CH];
    logic [LOG2_HEIGHT-1:0]    hi_v     [NUM_CH];
`endif

    assign accept = (state == LOAD) && valReady && valValid;

    // Row 0 is written on the MAP->SWEEP edge, so MAP compares against the freshly mapped rows.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            row_calc[c] = H_MAX - LOG2_HEIGHT'((PW'(val_q[c*VAL_RES +: VAL_RES]) * H_P) >> VAL_RES);
            row_src[c]  = (state == MAP) ? row_calc[c] : row_q[c];
`ifdef HDMI_WAVE_LINE_EN
            if (state == MAP)
                prev_src[c] = (x == '0) ? row_calc[c] : row_q[c];
            else
                prev_src[c] = prev_q[c];
`endif
        end
    end

    always_comb begin
        state_d   = state;
        row_cnt_d = row_cnt;
        x_d       = x;
        buf_d     = bufSel;
        wr_d      = 1'b0;
        wr_row    = row_cnt;
        frame_d   = 1'b0;
        case (state)
            LOAD: if (accept) state_d = MAP;
            MAP: begin
                state_d   = SWEEP;
                row_cnt_d = '0;
                wr_d      = 1'b1;
                wr_row    = '0;
            end
            SWEEP: begin
                if (row_cnt == H_MAX) begin
                    if (x == W_MAX) begin
                        state_d = SWAP;
                    end else begin
                        x_d     = x + 1'b1;
                        state_d = LOAD;
                    end
                end else begin
                    row_cnt_d = row_cnt + 1'b1;
                    wr_d      = 1'b1;
                    wr_row    = row_cnt + 1'b1;
                end
            end
            SWAP: begin
                if (swapAck) begin
                    buf_d   = ~bufSel;
                    x_d     = '0;
                    frame_d = 1'b1;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        wd_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef HDMI_WAVE_LINE_EN
            lo_v[c] = (prev_src[c] < row_src[c]) ? prev_src[c] : row_src[c];
            hi_v[c] = (prev_src[c] < row_src[c]) ? row_src[c] : prev_src[c];
            wd_d[c] = wr_d && (wr_row >= lo_v[c]) && (wr_row <= hi_v[c]);
`else
            wd_d[c] = wr_d && (wr_row == row_src[c]);
`endif
        end
    end

    always_ff @(posedge clkWR or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            row_cnt   <= '0;
            x         <= '0;
            val_q     <= '0;
            bufSel    <= 1'b0;
            valReady  <= 1'b0;
            swapReq   <= 1'b0;
            frameDone <= 1'b0;
            EN0       <= 1'b0;
            WE0       <= 1'b0;
            EN1       <= 1'b0;
            WE1       <= 1'b0;
            addrB0    <= '0;
            addrB1    <= '0;
            WD        <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                row_q[c] <= '0;
`ifdef HDMI_WAVE_LINE_EN
                prev_q[c] <= '0;
`endif
            end
        end else begin
            state     <= state_d;
            row_cnt   <= row_cnt_d;
            x         <= x_d;
            bufSel    <= buf_d;
            valReady  <= (state_d == LOAD);
            swapReq   <= (state_d == SWAP);
            frameDone <= frame_d;
            EN0       <= wr_d && !bufSel;
            WE0       <= wr_d && !bufSel;
            EN1       <= wr_d && bufSel;
            WE1       <= wr_d && bufSel;
            addrB0    <= (wr_d && !bufSel) ? ADDR_WIDTH'({wr_row, x}) : '0;
            addrB1    <= (wr_d && bufSel)  ? ADDR_WIDTH'({wr_row, x}) : '0;
            WD        <= wd_d;
            if (accept)
                val_q <= valIn;
            if (state == MAP) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    row_q[c] <= row_calc[c];
`ifdef HDMI_WAVE_LINE_EN
                    prev_q[c] <= prev_src[c];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_wave_writer.sv
// Directed bench for hdmi_wave_writer: column table plus swap, backpressure and reset sequences.
module tb_hdmi_wave_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] valIn = '0;
    logic        valValid = 1'b0;
    logic        swapAck = 1'b0;
    logic        valReady, swapReq, bufSel, frameDone;
    logic        EN0, WE0, EN1, WE1;
    logic [5:0]  addrB0, addrB1;
    logic [1:0]  WD;

    int nvec = 0;
    int nmis = 0;
    int prev0 = 0;
    int prev1 = 0;

    hdmi_wave_writer #(
        .NUM_CH(2), .VAL_RES(16), .WIDTH(8), .HEIGHT(6),
        .LOG2_WIDTH(3), .LOG2_HEIGHT(3), .ADDR_WIDTH(6)
    ) dut (
        .clkWR(clk), .rst(rst), .valIn(valIn), .valValid(valValid),
        .valReady(valReady), .swapReq(swapReq), .swapAck(swapAck),
        .bufSel(bufSel), .frameDone(frameDone),
        .EN0(EN0), .WE0(WE0), .EN1(EN1), .WE1(WE1),
        .addrB0(addrB0), .addrB1(addrB1), .WD(WD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v0;
        logic [15:0] v1;
        int          r0;
        int          r1;
        logic        hold;
    } col_t;

    col_t cols[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pk();
        return {14'b0, EN0, WE0, EN1, WE1, addrB0, addrB1, WD};
    endfunction

    function automatic logic [31:0] exp_pk(input logic b, input logic [5:0] a, input logic [1:0] wd);
        return {14'b0, !b, !b, b, b, (b ? 6'd0 : a), (b ? a : 6'd0), wd};
    endfunction

    function automatic logic exp_bit(input int r, input int row, input int prev);
`ifdef HDMI_WAVE_LINE_EN
        int lo, hi;
        lo = (prev < row) ? prev : row;
        hi = (prev < row) ? row : prev;
        return (r >= lo) && (r <= hi);
`else
        return (r == row) && (prev >= 0);
`endif
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!valReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'b0, valReady}, 32'd1);
    endtask

    task automatic run_col(input int idx, input int x, input logic b);
        int p0, p1;
        logic [1:0] wd;
        logic [5:0] a;
        wait_ready();
        valIn    = {cols[idx].v1, cols[idx].v0};
        valValid = 1'b1;
        @(negedge clk);
        if (cols[idx].hold) valIn = 32'hDEAD_BEEF;
        else valValid = 1'b0;
        chk("map_idle", pk(), 32'd0);
        chk("map_ready", {31'b0, valReady}, 32'd0);
        p0 = (x == 0) ? cols[idx].r0 : prev0;
        p1 = (x == 0) ? cols[idx].r1 : prev1;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            wd = {exp_bit(r, cols[idx].r1, p1), exp_bit(r, cols[idx].r0, p0)};
            a  = 6'(r * 8 + x);
            chk($sformatf("sweep c%0d r%0d", idx, r), pk(), exp_pk(b, a, wd));
        end
        @(negedge clk);
        valValid = 1'b0;
        chk("col_end_idle", pk(), 32'd0);
        chk("col_end_ready_swap", {30'b0, valReady, swapReq}, (x == 7) ? 32'd1 : 32'd2);
        prev0 = cols[idx].r0;
        prev1 = cols[idx].r1;
    endtask

    initial begin
        int bad;
        cols[0]  = '{16'h0000, 16'hFFFF, 5, 0, 1'b0};
        cols[1]  = '{16'h8000, 16'h0000, 2, 5, 1'b0};
        cols[2]  = '{16'hFFFF, 16'h8000, 0, 2, 1'b0};
        cols[3]  = '{16'h4000, 16'hC000, 4, 1, 1'b0};
        cols[4]  = '{16'h2AAA, 16'h2AAB, 5, 4, 1'b0};
        cols[5]  = '{16'h5555, 16'h5556, 4, 3, 1'b1};
        cols[6]  = '{16'hAAAA, 16'hD555, 2, 1, 1'b0};
        cols[7]  = '{16'h0001, 16'hFFFE, 5, 0, 1'b0};
        cols[8]  = '{16'hFFFF, 16'hFFFF, 0, 0, 1'b0};
        cols[9]  = '{16'h0000, 16'h8000, 5, 2, 1'b0};
        cols[10] = '{16'h0000, 16'h8000, 5, 2, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_strobes", pk(), 32'd0);
        chk("reset_ctrl", {28'b0, valReady, swapReq, bufSel, frameDone}, 32'd0);
        rst = 1'b0;
        #1 chk("ready_before_edge", {31'b0, valReady}, 32'd0);
        @(negedge clk);
        chk("ready_after_release", {31'b0, valReady}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_col(i, i, 1'b0);
            if (i == 2) begin
                swapAck = 1'b1;
                @(negedge clk);
                swapAck = 1'b0;
                chk("stray_ack", {30'b0, bufSel, swapReq}, 32'd0);
            end
            if (i == 4) begin
                bad = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (EN0 || EN1 || !valReady) bad++;
                end
                chk("backpressure", bad, 0);
            end
        end

        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!swapReq || EN0 || EN1 || bufSel || valReady) bad++;
        end
        chk("swap_wait", bad, 0);
        swapAck = 1'b1;
        @(negedge clk);
        swapAck = 1'b0;
        chk("swap_done", {28'b0, bufSel, swapReq, frameDone, valReady}, 32'hB);
        @(negedge clk);
        chk("frame_done_pulse", {31'b0, frameDone}, 32'd0);

        run_col(8, 0, 1'b1);
        run_col(9, 1, 1'b1);

        wait_ready();
        valIn    = 32'h4000_4000;
        valValid = 1'b1;
        @(negedge clk);
        valValid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_write", {30'b0, EN1, WE1}, 32'd3);
        #2 rst = 1'b1;
        #1 chk("reset_async", pk(), 32'd0);
        chk("reset_bufsel", {30'b0, bufSel, swapReq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_col(10, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
